// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Definitions shared by the fetch front end and the main controller:
//   instruction width, opcode constants and the fetch state encoding.
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_HALT   = 7'b1110101;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [6:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO with synchronous flush. The head entry is read straight
//   out of the storage registers, so a push into an empty FIFO becomes visible
//   on the following cycle (no bypass).
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   flush           empty the FIFO (wins over push/pop)
//   push, din       write an entry (accepted when not full, or full and popping)
//   pop             remove the head entry (ignored when empty)
//   dout            head entry
//   full, empty     status
//   count           current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[PW-2:0]] <= din;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   Fetch front end: issues sequential word fetches, queues in-order memory
//   responses with their PCs and presents one instruction per cycle to decode.
//   Redirect flushes the queue and discards responses still in flight; a
//   popped HALT stops fetching until reset.
//
//   state  | meaning
//   RUN    | fetching and delivering instructions
//   HALTED | HALT accepted; no requests, queue empty, Redirect ignored
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   IMemReq/Addr/Gnt      fetch request handshake (issued = Req && Gnt)
//   IMemValid/Data        in-order read responses
//   InstrValid/Instr/InstrPC/Opcode, InstrReady   queue head to decode
//   Redirect/RedirectPC   taken branch/jump: flush and refetch
//   Halted                fetch stopped by HALT
//   FetchCount/FlushCount pop and accepted-redirect counters
// Configuration
//   FETCH_PERF_EN  defined: counters implemented; undefined: tied to 0.
// ---------------------------------------------------------------------------
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int               ADDR_W   = 9,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemGnt,
  input  logic              IMemValid,
  input  logic [31:0]       IMemData,
  output logic              InstrValid,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] InstrPC,
  output logic [6:0]        Opcode,
  input  logic              InstrReady,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              Halted,
  output logic [31:0]       FetchCount,
  output logic [31:0]       FlushCount
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;

  fetch_state_t      state, state_nxt;
  logic              started;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     inflight_nxt;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     occ;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;
  logic              flush;
  logic              redirect_acc;
  logic              halt_enter;

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({IMemData, resp_pc}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  assign target_pc = RedirectPC & ~ADDR_W'(3);

  // Occupancy plus in-flight (including responses still to be discarded) is
  // bounded by DEPTH, so every response finds a free slot. 'started' keeps the
  // request low while reset is asserted.
  assign IMemReq  = started && (state == RUN) && !fifo_full &&
                    (({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(DEPTH));
  assign IMemAddr = pc;

  assign issue        = IMemReq && IMemGnt;
  assign resp         = IMemValid && (inflight != '0);
  assign inflight_nxt = inflight + CW'(issue) - CW'(resp);

  assign InstrValid = (state == RUN) && !fifo_empty;
  assign Instr      = InstrValid ? head[EW-1:ADDR_W] : '0;
  assign InstrPC    = InstrValid ? head[ADDR_W-1:0] : '0;
  assign Opcode     = Instr[6:0];
  assign Halted     = (state == HALTED);

  assign pop          = InstrValid && InstrReady;
  assign redirect_acc = (state == RUN) && Redirect;
  // Redirect in the same cycle marks the popped HALT as wrong-path.
  assign halt_enter   = pop && is_halt(Opcode) && !Redirect;
  assign flush        = redirect_acc || halt_enter || (state == HALTED);
  assign push         = resp && (drop == '0) && (state == RUN) && !flush;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt_enter) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  // resp_pc tracks the PC of the next response that will be kept: it restarts
  // at the redirect target and advances only on pushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= PC_RESET;
      resp_pc  <= PC_RESET;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_acc) begin
        pc      <= target_pc;
        resp_pc <= target_pc;
        drop    <= inflight_nxt;
      end else begin
        if (issue)                pc      <= pc + ADDR_W'(4);
        if (push)                 resp_pc <= resp_pc + ADDR_W'(4);
        if (resp && drop != '0)   drop    <= drop - 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop)          fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_acc) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt;
  assign FlushCount = flush_cnt;
`else
  assign FetchCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  import riscv_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;
  localparam int NW     = 128;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              IMemReq;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemGnt = 1'b0;
  logic              IMemValid = 1'b0;
  logic [31:0]       IMemData = '0;
  logic              InstrValid;
  logic [31:0]       Instr;
  logic [ADDR_W-1:0] InstrPC;
  logic [6:0]        Opcode;
  logic              InstrReady = 1'b0;
  logic              Redirect = 1'b0;
  logic [ADDR_W-1:0] RedirectPC = '0;
  logic              Halted;
  logic [31:0]       FetchCount;
  logic [31:0]       FlushCount;

  instr_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_RESET('0)) dut (
    .clk(clk), .reset(reset),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemValid(IMemValid), .IMemData(IMemData),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC), .Opcode(Opcode),
    .InstrReady(InstrReady), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Halted(Halted), .FetchCount(FetchCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_due = 0;
  int lat_lo = 1;
  int lat_hi = 1;

  logic [31:0] mem_words [NW];

  // memory: outstanding requests with their response cycle
  typedef struct { logic [ADDR_W-1:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];

  // reference: outstanding requests (wanted or wrong-path) and delivered queue
  typedef struct { logic live; logic [ADDR_W-1:0] pc; } out_t;
  typedef struct { logic [31:0] instr; logic [ADDR_W-1:0] pc; } ent_t;
  out_t ref_out[$];
  ent_t ref_q[$];
  logic [ADDR_W-1:0] ref_pc;
  bit   ref_halted;
  int   ref_fetch;
  int   ref_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ref_out.delete();
    ref_q.delete();
    mem_q.delete();
    ref_pc     = '0;
    ref_halted = 0;
    ref_fetch  = 0;
    ref_flush  = 0;
    last_due   = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    IMemReq, 0);
    check({tag, "_addr"},   IMemAddr, 0);
    check({tag, "_valid"},  InstrValid, 0);
    check({tag, "_instr"},  Instr, 0);
    check({tag, "_ipc"},    InstrPC, 0);
    check({tag, "_opc"},    Opcode, 0);
    check({tag, "_halted"}, Halted, 0);
    check({tag, "_fcnt"},   FetchCount, 0);
    check({tag, "_flcnt"},  FlushCount, 0);
  endtask

  function automatic int exp_count(input int v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs against the reference,
  // advance memory and reference, then step to just after the next edge.
  task automatic run_cycle(input bit gnt, input bit rdy, input bit red,
                           input logic [ADDR_W-1:0] rpc);
    bit resp_v, exp_req, exp_valid, issue, pop;
    logic [31:0] exp_instr;
    logic [ADDR_W-1:0] exp_ipc;
    out_t o;
    ent_t e;
    int due;
    o = '{1'b0, '0};
    resp_v = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    IMemValid  = resp_v;
    IMemData   = resp_v ? mem_words[mem_q[0].addr[ADDR_W-1:2]] : 32'h0;
    IMemGnt    = gnt;
    InstrReady = rdy;
    Redirect   = red;
    RedirectPC = rpc;
    #1;
    exp_req   = !ref_halted && (ref_q.size() + ref_out.size() < DEPTH);
    exp_valid = !ref_halted && (ref_q.size() > 0);
    exp_instr = exp_valid ? ref_q[0].instr : 32'h0;
    exp_ipc   = exp_valid ? ref_q[0].pc : '0;
    check("IMemReq",    IMemReq, exp_req);
    check("IMemAddr",   IMemAddr, ref_pc);
    check("InstrValid", InstrValid, exp_valid);
    check("Instr",      Instr, exp_instr);
    check("InstrPC",    InstrPC, exp_ipc);
    check("Opcode",     Opcode, exp_instr[6:0]);
    check("Halted",     Halted, ref_halted);
    check("FetchCount", FetchCount, exp_count(ref_fetch));
    check("FlushCount", FlushCount, exp_count(ref_flush));

    // memory answers what the DUT actually issued
    if (resp_v) void'(mem_q.pop_front());
    if (IMemReq && gnt) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{IMemAddr, due});
      last_due = due;
    end

    issue = exp_req && gnt;
    pop   = exp_valid && rdy;
    if (resp_v && ref_out.size() > 0) o = ref_out.pop_front();
    if (!ref_halted) begin
      if (pop) begin
        ref_fetch++;
        e = ref_q.pop_front();
        if (e.instr[6:0] == OPC_HALT && !red) ref_halted = 1;
      end
      if (resp_v && o.live && !ref_halted)
        ref_q.push_back('{mem_words[o.pc[ADDR_W-1:2]], o.pc});
      if (issue) begin
        ref_out.push_back('{1'b1, ref_pc});
        ref_pc = ref_pc + ADDR_W'(4);
      end
      if (red) begin
        ref_flush++;
        ref_q.delete();
        foreach (ref_out[i]) ref_out[i].live = 1'b0;
        ref_pc = rpc & ~ADDR_W'(3);
      end
      if (ref_halted) ref_q.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    IMemValid = 0; IMemData = '0; IMemGnt = 0;
    InstrReady = 0; Redirect = 0; RedirectPC = '0;
  endtask

  initial begin
    bit found;
    logic [31:0] w;
    for (int i = 0; i < NW; i++) begin
      w = $urandom;
      if (w[6:0] == OPC_HALT) w[0] = ~w[0];
      mem_words[i] = w;
    end

    // reset state
    #2;
    check_reset_outputs("reset");
    model_reset();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;

    // zero-wait memory, decode always ready
    lat_lo = 1; lat_hi = 1;
    repeat (12) run_cycle(1, 1, 0, '0);

    // decode stalled: queue fills to DEPTH, head held; then drains
    repeat (10) run_cycle(1, 0, 0, '0);
    repeat (8)  run_cycle(1, 1, 0, '0);

    // longer latency, redirect with responses in flight
    lat_lo = 3; lat_hi = 3;
    repeat (5) run_cycle(1, 1, 0, '0);
    run_cycle(1, 1, 1, 9'h40);
    repeat (12) run_cycle(1, 1, 0, '0);

    // random traffic
    lat_lo = 1; lat_hi = 3;
    for (int k = 0; k < 300; k++)
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0, ADDR_W'($urandom));

    // PC wrap at top of address space, low target bits ignored
    repeat (6) run_cycle(1, 1, 0, '0);
    run_cycle(1, 1, 1, 9'h1FE);
    repeat (8) run_cycle(1, 1, 0, '0);

    // HALT popped together with Redirect: stays in RUN
    mem_words[9'h80 >> 2] = 32'h0000_0075;
    lat_lo = 1; lat_hi = 1;
    run_cycle(1, 1, 1, 9'h80);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (ref_q.size() > 0 && ref_q[0].pc == 9'h80) found = 1;
      else run_cycle(1, 0, 0, '0);
    end
    check("halt_head_seen_1", found, 1);
    run_cycle(1, 1, 1, 9'h10);
    repeat (8) run_cycle(1, 1, 0, '0);

    // HALT popped alone: halts, later redirects ignored
    lat_lo = 1; lat_hi = 3;
    run_cycle(1, 1, 1, 9'h80);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (ref_halted) found = 1;
      else run_cycle(1, 1, 0, '0);
    end
    check("halt_reached", found, 1);
    for (int k = 0; k < 12; k++)
      run_cycle($urandom_range(0, 1), 1, $urandom_range(0, 1), ADDR_W'($urandom));

    // reset leaves HALTED; then asynchronous reset in the middle of a burst
    #3; reset = 0; idle_inputs();
    #1; check_reset_outputs("rst_halt");
    model_reset();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    repeat (7) run_cycle(1, 1, 0, '0);
    #3; reset = 0; idle_inputs();
    #1; check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    repeat (8) run_cycle(1, 1, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
